// File: rtl/layer_pingpong_buffer.sv
// Double-banked inter-layer buffer: one bank fills from the producing layer while
// the other streams, zero-padded out to READ_LEN words, to the consuming layer.
module layer_pingpong_buffer #(
  parameter int DATA_W    = 16,
  parameter int FRAME_LEN = 144,
  parameter int READ_LEN  = 160
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              out_last,
  output logic              frame_done,
  output logic              overflow
);

  localparam int                ADDR_W    = (READ_LEN > 1) ? $clog2(READ_LEN) : 1;
  localparam logic [ADDR_W:0]   FRAME_END = (ADDR_W + 1)'(FRAME_LEN);
  localparam logic [ADDR_W-1:0] WR_LAST   = ADDR_W'(FRAME_LEN - 1);
  localparam logic [ADDR_W-1:0] RD_LAST   = ADDR_W'(READ_LEN - 1);
  localparam logic              ONE_WORD  = (READ_LEN == 1);

  typedef enum logic {IDLE, STREAM} rd_state_t;

  logic [DATA_W-1:0] mem [2][FRAME_LEN];
  logic [1:0]        bank_full;
  logic              wr_bank;
  logic              rd_bank;
  logic [ADDR_W-1:0] wr_cnt;
  logic [ADDR_W-1:0] rd_cnt;
  logic [ADDR_W-1:0] rd_next;
  logic [DATA_W-1:0] next_word;
  logic              wr_fire;
  rd_state_t         rd_state;

  assign in_ready  = !bank_full[wr_bank];
  assign wr_fire   = in_valid && in_ready;
  assign rd_next   = rd_cnt + 1'b1;
  // Addresses past the stored frame read as zero padding.
  assign next_word = ({1'b0, rd_next} < FRAME_END) ? mem[rd_bank][rd_next] : '0;

  always_ff @(posedge clk) begin
    if (wr_fire && !rst) begin
      mem[wr_bank][wr_cnt] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_bank    <= 1'b0;
      rd_bank    <= 1'b0;
      wr_cnt     <= '0;
      rd_cnt     <= '0;
      bank_full  <= 2'b00;
      rd_state   <= IDLE;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_last   <= 1'b0;
      frame_done <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (in_valid && !in_ready) begin
        overflow <= 1'b1;
      end

      if (wr_fire) begin
        if (wr_cnt == WR_LAST) begin
          wr_cnt             <= '0;
          bank_full[wr_bank] <= 1'b1;
          wr_bank            <= !wr_bank;
          frame_done         <= 1'b1;
        end else begin
          wr_cnt <= wr_cnt + 1'b1;
        end
      end

      // The writer only completes an empty bank and the reader only releases a
      // full one, so the two bank_full updates never collide on one index.
      case (rd_state)
        IDLE: begin
          if (bank_full[rd_bank]) begin
            rd_state  <= STREAM;
            rd_cnt    <= '0;
            out_data  <= mem[rd_bank][0];
            out_valid <= 1'b1;
            out_last  <= ONE_WORD;
          end
        end
        STREAM: begin
          if (out_ready) begin
            if (rd_cnt == RD_LAST) begin
              bank_full[rd_bank] <= 1'b0;
              rd_bank            <= !rd_bank;
              rd_cnt             <= '0;
              if (bank_full[!rd_bank]) begin
                out_data <= mem[!rd_bank][0];
                out_last <= ONE_WORD;
              end else begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
                rd_state  <= IDLE;
              end
            end else begin
              rd_cnt   <= rd_next;
              out_data <= next_word;
              out_last <= (rd_next == RD_LAST);
            end
          end
        end
        default: rd_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_layer_pingpong_buffer.sv
// Scoreboard bench: a frame-level model predicts the output word stream and
// write-side flags; a negedge monitor pops and compares on every handshake.
module tb_layer_pingpong_buffer;

  localparam int DATA_W    = 16;
  localparam int FRAME_LEN = 144;
  localparam int READ_LEN  = 160;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic              last;
  } exp_t;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;
  logic              out_last;
  logic              frame_done;
  logic              overflow;

  logic       s_rst;
  logic       s_in_valid;
  logic [7:0] s_in_data;
  logic       s_in_ready;
  logic       s_out_valid;
  logic [7:0] s_out_data;
  logic       s_out_ready;
  logic       s_out_last;
  logic       s_frame_done;
  logic       s_overflow;

  int checks = 0;
  int errors = 0;
  int ready_mode = 1;

  exp_t              exp_q[$];
  logic [DATA_W-1:0] cur_q[$];
  int                pending = 0;
  logic              exp_fd = 1'b0;
  logic              exp_ovf = 1'b0;
  logic              prev_stall = 1'b0;
  logic [DATA_W-1:0] prev_data = '0;
  logic              prev_last = 1'b0;

  layer_pingpong_buffer #(.DATA_W(DATA_W), .FRAME_LEN(FRAME_LEN), .READ_LEN(READ_LEN)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready), .out_last(out_last),
    .frame_done(frame_done), .overflow(overflow)
  );

  layer_pingpong_buffer #(.DATA_W(8), .FRAME_LEN(4), .READ_LEN(4)) dut_small (
    .clk(clk), .rst(s_rst), .in_valid(s_in_valid), .in_data(s_in_data), .in_ready(s_in_ready),
    .out_valid(s_out_valid), .out_data(s_out_data), .out_ready(s_out_ready), .out_last(s_out_last),
    .frame_done(s_frame_done), .overflow(s_overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Consumer side: 0 = stalled, 1 = always ready, 2 = random, 3 = driven by the test.
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: out_ready = 1'b0;
        1: out_ready = 1'b1;
        2: out_ready = 1'($urandom_range(1));
        default: ;
      endcase
    end
  end

  // Model: a frame becomes readable when its last word is accepted; the writer
  // may accept while fewer than two completed frames are still unconsumed.
  always @(negedge clk) begin
    logic model_ready;
    exp_t e;
    model_ready = (pending < 2);
    checkOutput("in_ready", in_ready, model_ready);
    checkOutput("frame_done", frame_done, exp_fd);
    checkOutput("overflow", overflow, exp_ovf);
    if (prev_stall) begin
      checkOutput("hold_valid", out_valid, 1'b1);
      checkOutput("hold_data", out_data, prev_data);
      checkOutput("hold_last", out_last, prev_last);
    end
    if (out_valid) begin
      checkOutput("out_valid_expected", 32'(exp_q.size() != 0), 1);
    end
    if (out_valid && out_ready && exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checkOutput("out_data", out_data, e.data);
      checkOutput("out_last", out_last, e.last);
      if (e.last) pending--;
    end
    exp_fd = 1'b0;
    if (rst) begin
      exp_q.delete();
      cur_q.delete();
      pending    = 0;
      exp_ovf    = 1'b0;
      prev_stall = 1'b0;
    end else begin
      if (in_valid) begin
        if (model_ready) begin
          cur_q.push_back(in_data);
          if (cur_q.size() == FRAME_LEN) begin
            for (int i = 0; i < READ_LEN; i++) begin
              e.data = (i < FRAME_LEN) ? cur_q[i] : '0;
              e.last = (i == READ_LEN - 1);
              exp_q.push_back(e);
            end
            cur_q.delete();
            pending++;
            exp_fd = 1'b1;
          end
        end else begin
          exp_ovf = 1'b1;
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
    end
  end

  task automatic applyStimulus(input int base, input int count, input bit rnd_data,
                               input int gap_pct, input bit respect);
    int k = 0;
    while (k < count) begin
      if (gap_pct > 0 && int'($urandom_range(99)) < gap_pct) begin
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        continue;
      end
      in_valid = 1'b1;
      in_data  = rnd_data ? 16'($urandom) : 16'(base + k);
      @(negedge clk);
      if (respect && !in_ready) begin
        int w = 0;
        while (!in_ready && w < 2000) begin
          @(negedge clk);
          w++;
        end
        if (!in_ready) checkOutput("in_ready_timeout", in_ready, 1);
      end
      @(posedge clk);
      #1;
      k++;
    end
    in_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    int w = 0;
    @(negedge clk);
    while ((exp_q.size() != 0 || out_valid) && w < budget) begin
      @(negedge clk);
      w++;
    end
    if (w >= budget) checkOutput("drain_timeout", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic pulseReset();
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    logic [7:0] sv [4];
    int n;
    sv = '{8'h80, 8'h7f, 8'hff, 8'h01};
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    s_rst = 1'b1;
    s_in_valid = 1'b0;
    s_in_data = '0;
    s_out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_out_valid", out_valid, 0);
    checkOutput("reset_out_data", out_data, 0);
    checkOutput("reset_out_last", out_last, 0);
    checkOutput("reset_in_ready", in_ready, 1);
    @(posedge clk);
    #1;

    $display("[TB] single frame");
    ready_mode = 1;
    applyStimulus(1, FRAME_LEN, 0, 0, 1);
    @(negedge clk);
    checkOutput("latency_plus1", out_valid, 0);
    @(negedge clk);
    checkOutput("latency_plus2", out_valid, 1);
    checkOutput("latency_word0", out_data, 1);
    drain(1000);

    $display("[TB] ping-pong");
    fork
      begin
        applyStimulus(1000, FRAME_LEN, 0, 0, 1);
        applyStimulus(2000, FRAME_LEN, 0, 0, 1);
      end
      begin
        int w = 0;
        int cnt = 0;
        @(negedge clk);
        while (!out_valid && w < 1000) begin
          @(negedge clk);
          w++;
        end
        if (!out_valid) checkOutput("pingpong_start", out_valid, 1);
        repeat (2 * READ_LEN) begin
          if (out_valid) cnt++;
          @(negedge clk);
        end
        checkOutput("pingpong_gapless", cnt, 2 * READ_LEN);
      end
    join
    drain(1000);

    $display("[TB] random stalls");
    ready_mode = 2;
    applyStimulus(0, 3 * FRAME_LEN, 1, 30, 1);
    drain(5000);

    $display("[TB] backpressure");
    ready_mode = 0;
    applyStimulus(1, 2 * FRAME_LEN, 0, 0, 1);
    @(negedge clk);
    checkOutput("bp_in_ready_low", in_ready, 0);
    @(posedge clk);
    #1;
    applyStimulus(5000, 1, 0, 0, 0);
    @(negedge clk);
    checkOutput("bp_overflow", overflow, 1);
    ready_mode = 1;
    drain(2000);
    @(negedge clk);
    checkOutput("bp_overflow_sticky", overflow, 1);
    pulseReset();

    $display("[TB] reset mid-operation");
    ready_mode = 3;
    out_ready = 1'b0;
    applyStimulus(3000, FRAME_LEN, 0, 0, 1);
    fork
      applyStimulus(4000, 70, 0, 0, 1);
      begin
        int w = 0;
        @(negedge clk);
        while (!out_valid && w < 100) begin
          @(negedge clk);
          w++;
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        repeat (50) @(posedge clk);
        #1 out_ready = 1'b0;
      end
    join
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_out_data", out_data, 0);
    checkOutput("rst_out_last", out_last, 0);
    checkOutput("rst_in_ready", in_ready, 1);
    checkOutput("rst_overflow", overflow, 0);
    @(posedge clk);
    #1;
    ready_mode = 1;
    applyStimulus(6000, FRAME_LEN, 1, 10, 1);
    drain(1000);

    $display("[TB] small parameter set");
    s_rst = 1'b0;
    s_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s_in_valid = 1'b1;
      s_in_data  = sv[i];
      @(posedge clk);
      #1;
    end
    s_in_valid = 1'b0;
    n = 0;
    repeat (12) begin
      @(negedge clk);
      if (s_out_valid) begin
        if (n < 4) begin
          checkOutput("small_data", s_out_data, sv[n]);
          checkOutput("small_last", s_out_last, (n == 3));
        end
        n++;
      end
    end
    checkOutput("small_word_count", n, 4);
    checkOutput("small_overflow", s_overflow, 0);
    checkOutput("small_in_ready", s_in_ready, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/layer_pingpong_buffer.md
Name: layer_pingpong_buffer

Overview:
Parametrised double-banked (ping-pong) inter-layer buffer for the LeNet pipeline. It captures one feature-map frame of FRAME_LEN signed words from a producing layer into one bank. It then streams READ_LEN words from that bank to the consuming layer, zero-padding addresses at or beyond FRAME_LEN. Both sides use valid/ready handshakes, so producer and consumer may stall independently while the other bank fills or drains.

Parameters:
DATA_W, 16, width of signed data word
FRAME_LEN, 144, words written per frame (>=1)
READ_LEN, 160, words read per frame (>=FRAME_LEN); words FRAME_LEN..READ_LEN-1 read as 0
ADDR_W, clog2(READ_LEN), derived localparam, counter width

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
in_valid  in  1  producer word valid
in_data  in  DATA_W  producer word, signed
in_ready  out  1  buffer can accept a word this cycle
out_valid  out  1  out_data holds a valid word
out_data  out  DATA_W  consumer word, signed
out_ready  in  1  consumer accepts word this cycle
out_last  out  1  out_data is word READ_LEN-1 of the frame
frame_done  out  1  one-cycle pulse when a bank completes filling
overflow  out  1  sticky error: in_valid seen while in_ready low

Behaviour:
- Reset: synchronous on rst=1.
  - Outputs: out_valid=0, out_data=0, out_last=0, frame_done=0, overflow=0.
  - Internal state: wr_bank=0, rd_bank=0, wr_cnt=0, rd_cnt=0, both bank_full flags=0, read FSM=IDLE.
  - Memory contents are not reset.
  - rst mid-frame discards the partial frame and any queued full banks.
- Storage: 2 banks x FRAME_LEN words; only written addresses are stored.
- Write side:
  - in_ready = !bank_full[wr_bank]; combinational from registers only.
  - Accept when in_valid & in_ready: mem[wr_bank][wr_cnt] <= in_data; wr_cnt++.
  - On accepting word FRAME_LEN-1:
    - wr_cnt <= 0, bank_full[wr_bank] <= 1, wr_bank toggles.
    - frame_done=1 in the following cycle.
  - in_valid & !in_ready: word dropped, overflow <= 1 until rst.
- Read FSM states:
  - IDLE: if bank_full[rd_bank], go to STREAM, rd_cnt=0, load word 0 into the output register; out_valid=1 next cycle.
  - STREAM: output register advances when out_ready=1 (out_valid stays high between words; no bubbles).
  - Output word value: out_data = mem[rd_bank][rd_cnt] if rd_cnt < FRAME_LEN, else 0.
  - out_last=1 exactly when the presented word index is READ_LEN-1.
  - While out_ready=0: out_data, out_last and out_valid hold.
  - Handshake on the out_last word:
    - bank_full[rd_bank] <= 0 and rd_bank toggles.
    - If the other bank is already full, the FSM stays in STREAM and presents its word 0 in the next cycle (back-to-back frames, no gap).
    - Otherwise out_valid <= 0 and the FSM returns to IDLE.
- Latency: last input word accepted at cycle T; bank_full set at T+1; out_valid=1 with word 0 at T+2 when the reader is IDLE.
- Simultaneous events:
  - Write completion into bank A and read release of bank B in the same cycle both take effect.
  - A bank released at edge E accepts writes from cycle E+1, since in_ready recomputes from the cleared flag.
- Both banks full: in_ready=0 until the reader releases a bank; no data lost unless the producer ignores in_ready.
- Arithmetic: no arithmetic on data; counters wrap only via explicit compare to FRAME_LEN-1 and READ_LEN-1.
- Degenerate READ_LEN==FRAME_LEN: no padding words.

Test Plan:
- Single frame, default params: write 144 words 1..144 continuously, out_ready=1 -> frame_done pulse once. out_valid rises 2 cycles after the last write. Outputs are 1..144 then 16 zeros, out_last on the 160th word. Bank 0 is then empty.
- Ping-pong: write frames A (values 1000+i) and B (2000+i) back-to-back, out_ready=1 -> in_ready never drops. Output is A (160 words) immediately followed by B with no out_valid gap.
- Backpressure: write 3 frames with out_ready=0 -> in_ready falls after the 288th accepted word. A 289th in_valid is dropped and overflow=1. Then raise out_ready -> frames 1 and 2 stream; frame 3 is absent.
- Random stall: out_ready toggled pseudo-randomly during streaming -> output sequence identical to the stall-free case. out_data and out_last hold while out_ready=0.
- Reset mid-operation: assert rst after 70 words written and 50 words read -> next cycle all outputs are 0 and in_ready=1. A fresh frame then reads out correctly from bank 0.
- Parameter sweep: DATA_W=8, FRAME_LEN=4, READ_LEN=4 -> 4 words out with no padding. Negative values are preserved (0x80 reads back as 0x80).
